// File: rtl/rv_pkg.sv
// Shared RISC-V datapath types: register index width, data width and the
// writeback entry record held by the writeback queue.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wbq_fwd_match.sv
// Youngest-match forwarding search over the writeback queue entries for one
// register read port. Misses and rs == x0 return hit = 0, data = 0.
module wbq_fwd_match
  import rv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  wb_entry_t             entries_i [DEPTH],
  input  logic [DEPTH-1:0]      valid_i,
  input  logic [PTR_W-1:0]      tail_i,
  input  logic [REG_ADDR_W-1:0] rs_i,
  output logic                  hit_o,
  output logic [XLEN-1:0]       data_o
);

  logic [PTR_W-1:0] idx;

  // Walk from the oldest slot (tail - DEPTH) to the youngest (tail - 1);
  // a later match overrides an earlier one, so the youngest wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail_i - PTR_W'(k);
      if ((rs_i != '0) && valid_i[idx] && (entries_i[idx].rd == rs_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Circular writeback queue between producers and the register-file write
// port, with combinational forwarding of pending values to two read ports.
module writeback_queue
  import rv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = rv_pkg::XLEN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wb_valid,
  output logic                    wb_ready,
  input  logic [REG_ADDR_W-1:0]   wb_rd,
  input  logic [XLEN-1:0]         wb_data,
  input  logic                    port_busy,
  output logic                    RegWrite,
  output logic [REG_ADDR_W-1:0]   rd,
  output logic [XLEN-1:0]         write_data,
  input  logic [REG_ADDR_W-1:0]   rs1,
  input  logic [REG_ADDR_W-1:0]   rs2,
  output logic                    fwd1_hit,
  output logic                    fwd2_hit,
  output logic [XLEN-1:0]         fwd1_data,
  output logic [XLEN-1:0]         fwd2_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: a request transfers on a posedge where wb_valid && wb_ready;
  // wb_ready depends only on occupancy, never on wb_valid.

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  wb_entry_t        mem_q [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] offset;
  logic             non_empty;
  logic             enq;
  logic             deq;

  assign non_empty  = (count_q != '0);
  assign wb_ready   = (count_q < CNT_W'(DEPTH));
  assign RegWrite   = non_empty && !port_busy;
  assign deq        = RegWrite;
  // Writes to x0 complete the handshake but are dropped.
  assign enq        = wb_valid && wb_ready && (wb_rd != '0);
  assign rd         = non_empty ? mem_q[head_q].rd   : '0;
  assign write_data = non_empty ? mem_q[head_q].data : '0;
  assign count      = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) tail_d = tail_q + PTR_W'(1);
    if (deq) head_d = head_q + PTR_W'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin
    valid  = '0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset   = PTR_W'(i) - head_q;
      valid[i] = ({1'b0, offset} < count_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; liveness comes solely from the pointers and count.
  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= '{rd: wb_rd, data: wb_data};
  end

  wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .entries_i (mem_q),
    .valid_i   (valid),
    .tail_i    (tail_q),
    .rs_i      (rs1),
    .hit_o     (fwd1_hit),
    .data_o    (fwd1_data)
  );

  wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .entries_i (mem_q),
    .valid_i   (valid),
    .tail_i    (tail_q),
    .rs_i      (rs2),
    .hit_o     (fwd2_hit),
    .data_o    (fwd2_data)
  );

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: reset, single write, x0 discard, fill
// under stall, youngest forwarding, full with simultaneous events, mid reset.
module tb_writeback_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk;
  logic            rst_n;
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            port_busy;
  logic            RegWrite;
  logic [4:0]      rd;
  logic [XLEN-1:0] write_data;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            fwd1_hit;
  logic            fwd2_hit;
  logic [XLEN-1:0] fwd1_data;
  logic [XLEN-1:0] fwd2_data;
  logic [2:0]      count;

  int n_vec = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];

  writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .port_busy  (port_busy),
    .RegWrite   (RegWrite),
    .rd         (rd),
    .write_data (write_data),
    .rs1        (rs1),
    .rs2        (rs2),
    .fwd1_hit   (fwd1_hit),
    .fwd2_hit   (fwd2_hit),
    .fwd1_data  (fwd1_data),
    .fwd2_data  (fwd2_data),
    .count      (count)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid  = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    port_busy = 1'b0;
    rs1       = '0;
    rs2       = '0;
  endtask

  task automatic push_req(input logic [4:0] r, input logic [31:0] d);
    wb_valid = 1'b1;
    wb_rd    = r;
    wb_data  = d;
    tick();
    wb_valid = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    rs1 = 5'd5;
    rs2 = 5'd5;
    #22;
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_vec++; if (wb_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", wb_ready); end
    n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL reset_regwrite: got %b want 0", RegWrite); end
    n_vec++; if ({rd, write_data} !== 37'd0) begin n_err++; $display("FAIL reset_port: got rd=%0d data=%h want 0/0", rd, write_data); end
    n_vec++; if ({fwd1_hit, fwd1_data, fwd2_hit, fwd2_data} !== 66'd0) begin n_err++; $display("FAIL reset_fwd: got h1=%b d1=%h h2=%b d2=%h want zeros", fwd1_hit, fwd1_data, fwd2_hit, fwd2_data); end
    @(negedge clk);
    rst_n = 1'b1;
    rs1 = '0;
    rs2 = '0;
    tick();
  endtask

  task automatic test_single_write();
    wb_valid = 1'b1;
    wb_rd    = 5'd5;
    wb_data  = 32'hDEADBEEF;
    #1;
    n_vec++; if (wb_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", wb_ready); end
    tick();
    wb_valid = 1'b0;
    rs1 = 5'd5;
    #1;
    n_vec++; if (RegWrite !== 1'b1) begin n_err++; $display("FAIL single_regwrite: got %b want 1", RegWrite); end
    n_vec++; if (rd !== 5'd5) begin n_err++; $display("FAIL single_rd: got %0d want 5", rd); end
    n_vec++; if (write_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data: got %h want deadbeef", write_data); end
    n_vec++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", count); end
    n_vec++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_fwd_head: got h=%b d=%h want 1/deadbeef", fwd1_hit, fwd1_data); end
    tick();
    rs1 = '0;
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL single_count_after: got %0d want 0", count); end
    n_vec++; if (RegWrite !== 1'b0 || rd !== 5'd0 || write_data !== 32'd0) begin n_err++; $display("FAIL single_empty_port: got we=%b rd=%0d d=%h want 0/0/0", RegWrite, rd, write_data); end
  endtask

  task automatic test_x0_discard();
    wb_valid = 1'b1;
    wb_rd    = 5'd0;
    wb_data  = 32'hFF;
    #1;
    n_vec++; if (wb_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready: got %b want 1", wb_ready); end
    tick();
    wb_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL x0_count: got %0d want 0", count); end
      n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL x0_regwrite: got %b want 0", RegWrite); end
      tick();
    end
  endtask

  task automatic test_fill_stall();
    logic [36:0] exp;
    port_busy = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      wb_valid = 1'b1;
      wb_rd    = 5'(i + 1);
      wb_data  = 32'h100 + 32'(i);
      #1;
      n_vec++; if (wb_ready !== (i < 4)) begin n_err++; $display("FAIL fill_ready_%0d: got %b want %b", i, wb_ready, (i < 4)); end
      n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL fill_stall_we_%0d: got %b want 0", i, RegWrite); end
      if (i < 4) exp_q.push_back({wb_rd, wb_data});
      tick();
    end
    wb_valid = 1'b0;
    #1;
    n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_count: got %0d want 4", count); end
    n_vec++; if (wb_ready !== 1'b0) begin n_err++; $display("FAIL fill_full_ready: got %b want 0", wb_ready); end
    port_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp = exp_q.pop_front();
      n_vec++; if (RegWrite !== 1'b1 || {rd, write_data} !== exp) begin n_err++; $display("FAIL drain_%0d: got we=%b rd=%0d d=%h want 1/%0d/%h", i, RegWrite, rd, write_data, exp[36:32], exp[31:0]); end
      tick();
    end
    n_vec++; if (count !== 3'd0 || RegWrite !== 1'b0) begin n_err++; $display("FAIL drain_done: got count=%0d we=%b want 0/0", count, RegWrite); end
  endtask

  task automatic test_youngest_fwd();
    port_busy = 1'b1;
    push_req(5'd3, 32'h11);
    push_req(5'd3, 32'h22);
    push_req(5'd7, 32'h77);
    rs1 = 5'd3;
    rs2 = 5'd0;
    #1;
    n_vec++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h22) begin n_err++; $display("FAIL fwd_youngest: got h=%b d=%h want 1/22", fwd1_hit, fwd1_data); end
    n_vec++; if (fwd2_hit !== 1'b0 || fwd2_data !== 32'h0) begin n_err++; $display("FAIL fwd_x0: got h=%b d=%h want 0/0", fwd2_hit, fwd2_data); end
    rs2 = 5'd7;
    #1;
    n_vec++; if (fwd2_hit !== 1'b1 || fwd2_data !== 32'h77) begin n_err++; $display("FAIL fwd2_hit: got h=%b d=%h want 1/77", fwd2_hit, fwd2_data); end
    rs1 = 5'd9;
    #1;
    n_vec++; if (fwd1_hit !== 1'b0 || fwd1_data !== 32'h0) begin n_err++; $display("FAIL fwd_miss: got h=%b d=%h want 0/0", fwd1_hit, fwd1_data); end
    wb_valid = 1'b1;
    wb_rd    = 5'd9;
    wb_data  = 32'h99;
    #1;
    n_vec++; if (fwd1_hit !== 1'b0) begin n_err++; $display("FAIL fwd_incoming: got h=%b want 0", fwd1_hit); end
    tick();
    wb_valid = 1'b0;
    n_vec++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h99 || count !== 3'd4) begin n_err++; $display("FAIL fwd_stored: got h=%b d=%h cnt=%0d want 1/99/4", fwd1_hit, fwd1_data, count); end
    port_busy = 1'b0;
    rs1 = '0;
    rs2 = '0;
    for (int i = 0; i < 4; i++) tick();
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL fwd_drain: got %0d want 0", count); end
  endtask

  task automatic test_full_simul();
    logic [36:0] exp;
    port_busy = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({5'(10 + i), 32'hA0 + 32'(i)});
      push_req(5'(10 + i), 32'hA0 + 32'(i));
    end
    port_busy = 1'b0;
    wb_valid  = 1'b1;
    wb_rd     = 5'd14;
    wb_data   = 32'hA4;
    #1;
    n_vec++; if (wb_ready !== 1'b0 || RegWrite !== 1'b1) begin n_err++; $display("FAIL full_no_enq: got rdy=%b we=%b want 0/1", wb_ready, RegWrite); end
    tick();
    void'(exp_q.pop_front());
    n_vec++; if (count !== 3'd3 || wb_ready !== 1'b1) begin n_err++; $display("FAIL full_deq_only: got cnt=%0d rdy=%b want 3/1", count, wb_ready); end
    for (int j = 0; j < 6; j++) begin
      wb_rd   = 5'(14 + j);
      wb_data = 32'hA4 + 32'(j);
      #1;
      exp = exp_q[0];
      n_vec++; if (count !== 3'd3 || RegWrite !== 1'b1 || {rd, write_data} !== exp) begin n_err++; $display("FAIL simul_%0d: got cnt=%0d we=%b rd=%0d d=%h want 3/1/%0d/%h", j, count, RegWrite, rd, write_data, exp[36:32], exp[31:0]); end
      exp_q.push_back({wb_rd, wb_data});
      tick();
      void'(exp_q.pop_front());
    end
    wb_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      exp = exp_q.pop_front();
      n_vec++; if (RegWrite !== 1'b1 || {rd, write_data} !== exp) begin n_err++; $display("FAIL wrap_drain_%0d: got we=%b rd=%0d d=%h want 1/%0d/%h", i, RegWrite, rd, write_data, exp[36:32], exp[31:0]); end
      tick();
    end
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL wrap_empty: got %0d want 0", count); end
  endtask

  task automatic test_reset_mid_drain();
    port_busy = 1'b1;
    push_req(5'd20, 32'hC0);
    push_req(5'd21, 32'hC1);
    push_req(5'd22, 32'hC2);
    port_busy = 1'b0;
    #1;
    n_vec++; if (RegWrite !== 1'b1 || rd !== 5'd20) begin n_err++; $display("FAIL mid_first: got we=%b rd=%0d want 1/20", RegWrite, rd); end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (RegWrite !== 1'b0 || count !== 3'd0 || wb_ready !== 1'b1 || rd !== 5'd0) begin n_err++; $display("FAIL mid_async: got we=%b cnt=%0d rdy=%b rd=%0d want 0/0/1/0", RegWrite, count, wb_ready, rd); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++; if (RegWrite !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL mid_after_%0d: got we=%b cnt=%0d want 0/0", c, RegWrite, count); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_x0_discard();
    test_fill_stall();
    test_youngest_fwd();
    test_full_simul();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queue entries (power of two, 2..16).
REQ-002 SHALL have parameter XLEN, default 32, meaning the data width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have port wb_valid  input  1  meaning a producer presents a writeback request.
REQ-006 SHALL have port wb_ready  output  1  meaning the queue accepts a request this cycle.
REQ-007 SHALL have port wb_rd  input  5  meaning the destination register index.
REQ-008 SHALL have port wb_data  input  XLEN  meaning the writeback value.
REQ-009 SHALL have port port_busy  input  1  meaning the register-file write port is unavailable this cycle.
REQ-010 SHALL have port RegWrite  output  1  meaning the write enable to the register file.
REQ-011 SHALL have port rd  output  5  meaning the register-file write index.
REQ-012 SHALL have port write_data  output  XLEN  meaning the register-file write value.
REQ-013 SHALL have ports rs1 and rs2  input  5 each  meaning the read indices being looked up.
REQ-014 SHALL have ports fwd1_hit and fwd2_hit  output  1 each  meaning a pending entry matches rs1 or rs2.
REQ-015 SHALL have ports fwd1_data and fwd2_data  output  XLEN each  meaning the forwarded value, or 0 on a miss.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  meaning the number of occupied entries.

Function
REQ-017 SHALL be a circular FIFO with head and tail pointers that wrap modulo DEPTH.
REQ-018 SHALL drive wb_ready = (count < DEPTH) combinationally, with no dependence on wb_valid.
REQ-019 SHALL enqueue {wb_rd, wb_data} at the tail on a posedge where wb_valid && wb_ready, and SHALL increment the tail.
REQ-020 SHALL accept a request with wb_rd == 0 (the handshake completes) but SHALL NOT store it, so count is unchanged.
REQ-021 SHALL drive RegWrite = (count != 0) && !port_busy, with rd and write_data taken from the head entry.
REQ-022 SHALL drive rd = 0 and write_data = 0 when count == 0.
REQ-023 SHALL dequeue the head on every posedge where RegWrite is 1, which is the same edge on which the register file latches it.
REQ-024 SHALL give a minimum latency of one cycle: a request accepted at edge N is presented at the write port during cycle N+1.
REQ-025 SHALL update count by +1 on enqueue only, -1 on dequeue only, and 0 on simultaneous enqueue and dequeue.
REQ-026 SHALL allow simultaneous enqueue and dequeue when count == DEPTH-1 and when 0 < count < DEPTH.
REQ-027 SHALL NOT allow enqueue when count == DEPTH, even if a dequeue occurs on the same edge.
REQ-028 SHALL compute forwarding combinationally over the stored entries only, including the head entry being written this cycle.
REQ-029 SHALL select the youngest matching entry (closest to the tail) when multiple entries match.
REQ-030 SHALL drive fwd1_hit = 0 whenever rs1 == 0, and fwd2_hit = 0 whenever rs2 == 0.
REQ-031 SHALL NOT forward from the incoming wb_* request in the cycle it is presented.
REQ-032 SHALL hold all entries, with no dequeue, while port_busy == 1; enqueue SHALL continue until the queue is full.

Reset
REQ-033 SHALL, on rst_n low, immediately clear the head, tail and count, independent of clk.
REQ-034 SHALL, while in reset, drive RegWrite = 0, rd = 0, write_data = 0, fwd*_hit = 0, fwd*_data = 0 and wb_ready = 1.
REQ-035 SHALL discard queued entries when reset asserts mid-operation, with no write emitted afterwards.
REQ-036 SHALL NOT reset the entry storage (data is don't-care while invalid); the valid state derives only from the pointers and count.

Structure
REQ-037 SHALL take XLEN, REG_ADDR_W = 5 and the struct wb_entry_t {rd, data} from the shared package rv_pkg.
REQ-038 SHALL instantiate one sub-module, wbq_fwd_match, per read port; each performs the youngest-match priority search given the entry array, valid mask, tail and rs.

Verification
REQ-039 Reset then single write SHALL work: enqueue rd = 5, data = 0xDEADBEEF -> next cycle RegWrite = 1, rd = 5, write_data = 0xDEADBEEF; then count returns to 0.
REQ-040 Fill under stall SHALL work: port_busy = 1, offer 5 requests -> 4 accepted, wb_ready = 0 with count = 4; release port_busy -> 4 writes in order on consecutive cycles.
REQ-041 Youngest forwarding SHALL work: queue x3 = 0x11 then x3 = 0x22 under stall, rs1 = 3 -> fwd1_hit = 1, fwd1_data = 0x22; with rs2 = 0 -> fwd2_hit = 0.
REQ-042 x0 discard SHALL work: wb_rd = 0, wb_data = 0xFF accepted -> count stays 0, RegWrite never asserts.
REQ-043 Full with simultaneous events SHALL work: count = 3 of 4, port free, wb_valid held high -> enqueue and dequeue on the same edge, count stays 3, pointers wrap past DEPTH-1 correctly.
REQ-044 Reset mid-drain SHALL work: 3 entries queued, assert rst_n low between edges -> RegWrite = 0 immediately, count = 0, no further writes after release.
